mm_game_sequencer: RTL
======================

// Module: mm_game_sequencer
// PURPOSE
//  Game-level controller for the mastermind guess core: picks the secret, re-arms the
//  core per game, scores each checked guess (exact/partial pegs) over multiple cycles,
//  and keeps win/loss tallies. It sits between the board top level and the core, watching
//  the core's one-hot state flags and driving its reset and correct_answer.
// PARAMETERS
//  LFSR_SEED        16'hACE1  LFSR reset value (must be nonzero)
//  CORE_RST_CYCLES  2         cycles core_reset is held high per game start (>=1)
//  CNT_W            8         width of wins/losses counters
// PORTS
//  Clk             in   1      clock
//  Reset           in   1      asynchronous, active-high reset
//  BtnStart        in   1      debounced single-cycle pulse: start new game
//  ans_load        in   1      sampled with BtnStart: 1 = use ans_value instead of LFSR
//  ans_value       in   12     forced secret (bench/demo)
//  q_Check         in   1      core in CHECK state
//  q_DoneC         in   1      core in DONEC (guessed correctly)
//  q_DoneNC        in   1      core in DONENC (out of guesses)
//  current_guess   in   12     core guess, field i = bits [3i+2:3i]
//  core_reset      out  1      reset pulse to core
//  correct_answer  out  12     secret to core, stable from game start to next start
//  exact_cnt       out  3      positions with matching colour (0..4)
//  partial_cnt     out  3      right colour, wrong position (0..4)
//  fb_valid        out  1      one-cycle pulse: exact_cnt/partial_cnt updated
//  busy            out  1      high in ARM, EXACT, PART, REPORT
//  game_over       out  1      high in OVER
//  overrun         out  1      sticky: q_Check seen while scoring; cleared on game start
//  wins, losses    out  CNT_W  saturating game tallies
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; LFSR=LFSR_SEED; done-pending flags cleared.
//  LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts every cycle in all states.
//  Secret: fields from ans_value (ans_load=1) or LFSR[11:0]; any field equal to 0 (empty)
//   is replaced by 3'd7. Latched into correct_answer on the BtnStart edge.
//  States:
//   IDLE   - BtnStart -> ARM.
//   ARM    - core_reset=1 for exactly CORE_RST_CYCLES cycles, then -> WAIT.
//   WAIT   - q_Check=1 -> capture current_guess, clear used-flags -> EXACT.
//   EXACT  - 4 cycles, i=0..3: exact_flag[i]=(g[i]==s[i]); count into exact accumulator.
//   PART   - 16 cycles, i outer 0..3, j inner 0..3: if !exact_flag[i], !matched[i],
//            !exact_flag[j], !used[j], g[i]==s[j] -> partial++, used[j]=1, matched[i]=1
//            (lowest j wins; duplicates are never double-counted).
//   REPORT - 1 cycle: exact_cnt/partial_cnt load accumulators, fb_valid=1. Then pending
//            DoneC -> wins++ ; pending DoneNC -> losses++ ; either -> OVER, else -> WAIT.
//   OVER   - BtnStart -> ARM.
//  Latency: fb_valid is high in the cycle following the 21st rising edge after the capture
//   edge (4 EXACT + 16 PART + 1 REPORT); fixed, data-independent.
//  q_DoneC/q_DoneNC seen in any of WAIT/EXACT/PART/REPORT set a pending flag; applied
//   only at REPORT. If seen in WAIT with no scoring in flight, go straight to OVER and
//   count. DoneC has priority if both set.
//  q_Check while in EXACT/PART/REPORT: ignored, overrun<=1; scoring unaffected.
//  BtnStart in WAIT/EXACT/PART/REPORT: abandon game (no tally change), new secret -> ARM.
//  BtnStart during ARM: ignored.
//  wins/losses saturate at all-ones; never wrap.
//  exact_cnt/partial_cnt hold their values until the next REPORT; cleared only by Reset.
//  Reset mid-operation: immediate return to reset values, including tallies.
// TESTING
//  1. Reset, idle 10 cycles -> all outputs 0, state IDLE, core_reset never pulses.
//  2. BtnStart, ans_load=1, ans_value=12'h000 -> core_reset high exactly 2 cycles;
//     correct_answer=12'hFFF (all fields mapped to 7).
//  3. Secret 12'h8D1 (1,2,3,4), q_Check with guess 12'h29C (4,3,2,1) -> 21 edges later
//     fb_valid=1 for 1 cycle, exact=0, partial=4.
//  4. Secret 12'h489 (1,1,2,2), guess 12'h651 (1,2,1,3) -> exact=1, partial=2;
//     repeat q_Check mid-PART -> overrun=1, results unchanged.
//  5. q_DoneNC asserted during PART -> losses=1 and game_over=1 only after fb_valid;
//     q_DoneC in the next game -> wins=1.
//  6. Assert Reset during PART -> fb_valid never fires; all outputs 0; next start works.

Source files
------------

// File: rtl/mm_game_sequencer_if.sv
// Signal bundle between the mastermind game sequencer and its surroundings
// (board buttons and the guess core).
// The master modport is the sequencer's side of the bundle.
// The slave modport is the board/core side.
interface mm_game_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             BtnStart;
  logic             ans_load;
  logic [11:0]      ans_value;
  logic             q_Check;
  logic             q_DoneC;
  logic             q_DoneNC;
  logic [11:0]      current_guess;
  logic             core_reset;
  logic [11:0]      correct_answer;
  logic [2:0]       exact_cnt;
  logic [2:0]       partial_cnt;
  logic             fb_valid;
  logic             busy;
  logic             game_over;
  logic             overrun;
  logic [CNT_W-1:0] wins;
  logic [CNT_W-1:0] losses;

  modport master (
    input  BtnStart, ans_load, ans_value, q_Check, q_DoneC, q_DoneNC, current_guess,
    output core_reset, correct_answer, exact_cnt, partial_cnt, fb_valid, busy,
           game_over, overrun, wins, losses
  );

  modport slave (
    output BtnStart, ans_load, ans_value, q_Check, q_DoneC, q_DoneNC, current_guess,
    input  core_reset, correct_answer, exact_cnt, partial_cnt, fb_valid, busy,
           game_over, overrun, wins, losses
  );
endinterface

// File: rtl/mm_game_sequencer.sv
// Mastermind game sequencer.
// It picks the secret and re-arms the guess core at each game start.
// Each checked guess is scored serially: 4 exact cycles, 16 partial cycles,
// then 1 report cycle.
// It keeps saturating win/loss tallies.
module mm_game_sequencer #(
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          CORE_RST_CYCLES = 2,
  parameter int          CNT_W           = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  mm_game_sequencer_if.master  bus
);

  localparam int ARM_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(CORE_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_WAIT   = 3'd2,
    S_EXACT  = 3'd3,
    S_PART   = 3'd4,
    S_REPORT = 3'd5,
    S_OVER   = 3'd6
  } state_e;

  // Colour field k of a packed 4-field word.
  function automatic logic [2:0] fld(input logic [11:0] v, input logic [1:0] k);
    logic [2:0] r;
    case (k)
      2'd0:    r = v[2:0];
      2'd1:    r = v[5:3];
      2'd2:    r = v[8:6];
      2'd3:    r = v[11:9];
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Empty (zero) fields are not legal colours; force them to colour 7.
  function automatic logic [11:0] map_secret(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int k = 0; k < 4; k++) begin
      if (v[3*k +: 3] == 3'd0) begin
        r[3*k +: 3] = 3'd7;
      end else begin
        r[3*k +: 3] = v[3*k +: 3];
      end
    end
    return r;
  endfunction

  // Saturating tally increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [11:0]      secret_q, secret_d;
  logic [11:0]      guess_q, guess_d;
  logic [3:0]       idx_q, idx_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [3:0]       ex_flag_q, ex_flag_d;
  logic [3:0]       matched_q, matched_d;
  logic [3:0]       used_q, used_d;
  logic [2:0]       acc_e_q, acc_e_d;
  logic [2:0]       acc_p_q, acc_p_d;
  logic [2:0]       exact_cnt_q, exact_cnt_d;
  logic [2:0]       partial_cnt_q, partial_cnt_d;
  logic             fb_valid_q, fb_valid_d;
  logic             overrun_q, overrun_d;
  logic             pend_c_q, pend_c_d;
  logic             pend_nc_q, pend_nc_d;
  logic [CNT_W-1:0] wins_q, wins_d;
  logic [CNT_W-1:0] losses_q, losses_d;
  logic             busy_q, game_over_q, core_reset_q;

  logic       start_s, scoring_s, tracking_s, done_c_s, done_nc_s, hit_s;
  logic [1:0] pi_s, pj_s;

  // Next-state, scoring datapath and tally logic.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    secret_d      = secret_q;
    guess_d       = guess_q;
    idx_d         = idx_q;
    arm_cnt_d     = arm_cnt_q;
    ex_flag_d     = ex_flag_q;
    matched_d     = matched_q;
    used_d        = used_q;
    acc_e_d       = acc_e_q;
    acc_p_d       = acc_p_q;
    exact_cnt_d   = exact_cnt_q;
    partial_cnt_d = partial_cnt_q;
    fb_valid_d    = 1'b0;
    wins_d        = wins_q;
    losses_d      = losses_q;

    start_s    = bus.BtnStart && (state_q != S_ARM);
    scoring_s  = (state_q == S_EXACT) || (state_q == S_PART) || (state_q == S_REPORT);
    tracking_s = scoring_s || (state_q == S_WAIT);
    done_c_s   = pend_c_q || bus.q_DoneC;
    done_nc_s  = pend_nc_q || bus.q_DoneNC;
    pi_s       = idx_q[3:2];
    pj_s       = idx_q[1:0];
    hit_s      = !ex_flag_q[pi_s] && !matched_q[pi_s] && !ex_flag_q[pj_s] && !used_q[pj_s]
                 && (fld(guess_q, pi_s) == fld(secret_q, pj_s));

    overrun_d = overrun_q || (scoring_s && bus.q_Check);
    pend_c_d  = pend_c_q || (tracking_s && bus.q_DoneC);
    pend_nc_d = pend_nc_q || (tracking_s && bus.q_DoneNC);

    if (start_s) begin
      // A start outside ARM always begins a fresh game; any game in flight is dropped.
      state_d   = S_ARM;
      secret_d  = map_secret(bus.ans_load ? bus.ans_value : lfsr_q[11:0]);
      arm_cnt_d = '0;
      overrun_d = 1'b0;
      pend_c_d  = 1'b0;
      pend_nc_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_ARM: begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d   = S_WAIT;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
          end
        end
        S_WAIT: begin
          if (done_c_s) begin
            wins_d    = sat_inc(wins_q);
            state_d   = S_OVER;
            pend_c_d  = 1'b0;
            pend_nc_d = 1'b0;
          end else if (done_nc_s) begin
            losses_d  = sat_inc(losses_q);
            state_d   = S_OVER;
            pend_c_d  = 1'b0;
            pend_nc_d = 1'b0;
          end else if (bus.q_Check) begin
            guess_d   = bus.current_guess;
            ex_flag_d = 4'b0000;
            matched_d = 4'b0000;
            used_d    = 4'b0000;
            acc_e_d   = 3'd0;
            acc_p_d   = 3'd0;
            idx_d     = 4'd0;
            state_d   = S_EXACT;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_EXACT: begin
          ex_flag_d[pj_s] = (fld(guess_q, pj_s) == fld(secret_q, pj_s));
          acc_e_d         = acc_e_q + {2'b00, ex_flag_d[pj_s]};
          if (pj_s == 2'd3) begin
            idx_d   = 4'd0;
            state_d = S_PART;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        S_PART: begin
          // i = idx[3:2] (guess position), j = idx[1:0] (secret position); lowest j wins.
          if (hit_s) begin
            acc_p_d         = acc_p_q + 3'd1;
            used_d[pj_s]    = 1'b1;
            matched_d[pi_s] = 1'b1;
          end else begin
            acc_p_d = acc_p_q;
          end
          if (idx_q == 4'd15) begin
            idx_d   = 4'd0;
            state_d = S_REPORT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        S_REPORT: begin
          exact_cnt_d   = acc_e_q;
          partial_cnt_d = acc_p_q;
          fb_valid_d    = 1'b1;
          if (done_c_s) begin
            wins_d    = sat_inc(wins_q);
            state_d   = S_OVER;
            pend_c_d  = 1'b0;
            pend_nc_d = 1'b0;
          end else if (done_nc_s) begin
            losses_d  = sat_inc(losses_q);
            state_d   = S_OVER;
            pend_c_d  = 1'b0;
            pend_nc_d = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_OVER:  state_d = S_OVER;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs; Reset returns everything to power-up values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      secret_q      <= 12'd0;
      guess_q       <= 12'd0;
      idx_q         <= 4'd0;
      arm_cnt_q     <= '0;
      ex_flag_q     <= 4'd0;
      matched_q     <= 4'd0;
      used_q        <= 4'd0;
      acc_e_q       <= 3'd0;
      acc_p_q       <= 3'd0;
      exact_cnt_q   <= 3'd0;
      partial_cnt_q <= 3'd0;
      fb_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      pend_c_q      <= 1'b0;
      pend_nc_q     <= 1'b0;
      wins_q        <= '0;
      losses_q      <= '0;
      busy_q        <= 1'b0;
      game_over_q   <= 1'b0;
      core_reset_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      secret_q      <= secret_d;
      guess_q       <= guess_d;
      idx_q         <= idx_d;
      arm_cnt_q     <= arm_cnt_d;
      ex_flag_q     <= ex_flag_d;
      matched_q     <= matched_d;
      used_q        <= used_d;
      acc_e_q       <= acc_e_d;
      acc_p_q       <= acc_p_d;
      exact_cnt_q   <= exact_cnt_d;
      partial_cnt_q <= partial_cnt_d;
      fb_valid_q    <= fb_valid_d;
      overrun_q     <= overrun_d;
      pend_c_q      <= pend_c_d;
      pend_nc_q     <= pend_nc_d;
      wins_q        <= wins_d;
      losses_q      <= losses_d;
      busy_q        <= (state_d == S_ARM) || (state_d == S_EXACT) ||
                       (state_d == S_PART) || (state_d == S_REPORT);
      game_over_q   <= (state_d == S_OVER);
      core_reset_q  <= (state_d == S_ARM);
    end
  end

  assign bus.core_reset     = core_reset_q;
  assign bus.correct_answer = secret_q;
  assign bus.exact_cnt      = exact_cnt_q;
  assign bus.partial_cnt    = partial_cnt_q;
  assign bus.fb_valid       = fb_valid_q;
  assign bus.busy           = busy_q;
  assign bus.game_over      = game_over_q;
  assign bus.overrun        = overrun_q;
  assign bus.wins           = wins_q;
  assign bus.losses         = losses_q;

endmodule
